sub2_pipe: RTL

SUB2_PIPE -- requirements
Module: sub2_pipe

---
 rtl/sub2_pkg.sv | 23 ++
 rtl/sub2_stage.sv | 25 ++
 rtl/sub2_pipe.sv | 107 ++++++++++
 3 files changed

// File: rtl/sub2_pkg.sv
// Shared defaults, the pipeline stage record and a small sizing helper for sub2_pipe.
package sub2_pkg;

  // Default operand width and pipeline depth.
  localparam int WIDTH_DEF   = 4;
  localparam int LATENCY_DEF = 5;

  // One pipeline stage at the default width. Field order is fixed: valid is
  // the MSB, then the recovered operand, then the two range flags. The top
  // module mirrors this layout for non-default widths.
  typedef struct packed {
    logic                 valid;
    logic [WIDTH_DEF-1:0] a;
    logic                 underflow;
    logic                 overrange;
  } stage_t;

  // Bits needed to count 0..latency samples in flight.
  function automatic int occ_width(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/sub2_stage.sv
// One enabled pipeline register with asynchronous active-low clear.
module sub2_stage #(
  parameter int DW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);

  logic [DW-1:0] r_q;

  // Load the previous stage when enabled; hold during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sub2_pipe.sv
// Pipelined subtractor recovering a = sum - b with underflow/overrange flags.
// The subtraction happens in front of the first register; later stages only
// delay. The whole chain freezes while the output is valid but not taken.
module sub2_pipe
  import sub2_pkg::*;
#(
  parameter  int WIDTH   = WIDTH_DEF,
  parameter  int LATENCY = LATENCY_DEF,
  localparam int OCC_W   = occ_width(LATENCY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH:0]   sum,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic             underflow,
  output logic             overrange,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);

  // Same layout as sub2_pkg::stage_t, sized by this instance's WIDTH.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic             underflow;
    logic             overrange;
  } stage_w_t;

  localparam int SW = $bits(stage_w_t);

  logic             w_stall;
  logic             w_en;
  logic             w_accept;
  logic             w_take;
  logic [WIDTH+1:0] w_diff;
  stage_w_t         w_stage_in;
  stage_w_t         w_stage_d [0:LATENCY-1];
  stage_w_t         w_stage_q [0:LATENCY-1];
  stage_w_t         w_last;
  logic [OCC_W-1:0] r_occupancy;

  // Handshake: a valid result that is not taken freezes every stage.
  assign w_last   = w_stage_q[LATENCY-1];
  assign w_stall  = w_last.valid & ~out_ready;
  assign w_en     = ~w_stall;
  assign in_ready = ~w_stall;
  assign w_accept = in_valid & in_ready;
  assign w_take   = w_last.valid & out_ready;

  // sum minus zero-extended b, two bits wider than b so the sign is kept.
  assign w_diff = {1'b0, sum} - {2'b00, b};

  // Build the first stage record; a cycle without an accept is an all-zero bubble.
  always_comb begin
    w_stage_in = '0;
    if (w_accept) begin
      w_stage_in.valid     = 1'b1;
      w_stage_in.a         = w_diff[WIDTH-1:0];
      w_stage_in.underflow = w_diff[WIDTH+1];
      w_stage_in.overrange = ~w_diff[WIDTH+1] & w_diff[WIDTH];
    end
  end

  // Chain of LATENCY identical registers sharing one enable.
  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign w_stage_d[gi] = w_stage_in;
    end else begin : g_rest
      assign w_stage_d[gi] = w_stage_q[gi-1];
    end

    sub2_stage #(
      .DW (SW)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_en),
      .i_d   (w_stage_d[gi]),
      .o_q   (w_stage_q[gi])
    );
  end

  // Count samples in flight; accept and take in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occupancy <= '0;
    end else begin
      case ({w_accept, w_take})
        2'b10:   r_occupancy <= r_occupancy + OCC_W'(1);
        2'b01:   r_occupancy <= r_occupancy - OCC_W'(1);
        default: r_occupancy <= r_occupancy;
      endcase
    end
  end

  // Result outputs are forced to zero whenever no result is present.
  assign out_valid = w_last.valid;
  assign a         = w_last.valid ? w_last.a : '0;
  assign underflow = w_last.valid & w_last.underflow;
  assign overrange = w_last.valid & w_last.overrange;
  assign occupancy = r_occupancy;

endmodule
